// File: rtl/fslcd_drv.sv
// Parallel-RGB LCD driver: 2-stage pixel/sync pipeline, width reduction and panel power/backlight sequencer.
// Optional ordered dither is enabled by defining FSLCD_DITHER_EN (needs C_IN_COMP_WIDTH - C_OUT_COMP_WIDTH >= 2).
module fslcd_drv #(
    parameter int C_IN_COMP_WIDTH  = 8,
    parameter int C_OUT_COMP_WIDTH = 6,
    parameter int C_PWR_DLY        = 1000000,
    parameter int C_BL_DLY         = 1000000,
    parameter int C_HSYNC_POL      = 1,
    parameter int C_VSYNC_POL      = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          lcd_en,
    input  logic                          vid_active,
    input  logic [3*C_IN_COMP_WIDTH-1:0]  vid_data,
    input  logic                          hsync,
    input  logic                          vsync,
    output logic                          clk_out,
    output logic [C_OUT_COMP_WIDTH-1:0]   r,
    output logic [C_OUT_COMP_WIDTH-1:0]   g,
    output logic [C_OUT_COMP_WIDTH-1:0]   b,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic [3:0]                    ctrl_out,
    output logic                          pwr_ready
);
    localparam int W     = C_IN_COMP_WIDTH;
    localparam int WO    = C_OUT_COMP_WIDTH;
    localparam int CNT_W = (C_PWR_DLY > C_BL_DLY) ? $clog2(C_PWR_DLY + 1) : $clog2(C_BL_DLY + 1);
    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(C_PWR_DLY - 1);
    localparam logic [CNT_W-1:0] BL_LOAD  = CNT_W'(C_BL_DLY - 1);
    localparam logic HS_ACT = (C_HSYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ACT = (C_VSYNC_POL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWR_UP = 3'd1,
        ST_BL_UP  = 3'd2,
        ST_RUN    = 3'd3,
        ST_BL_DN  = 3'd4,
        ST_PWR_DN = 3'd5
    } state_t;

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pwr_r;
    logic             bl_r;
    logic             ready_r;
    logic             de_r;
    logic             act_s1_r;
    logic             hs_s1_r;
    logic             vs_s1_r;
    logic [3*W-1:0]   pix_s1_r;

    assign clk_out   = clk;
    assign rst_n_s   = rst_sync_r[1];
    assign ctrl_out  = {1'b0, bl_r, pwr_r, de_r};
    assign pwr_ready = ready_r;

    // Reset synchronizer: asserts immediately, releases on the second clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    // Power/backlight sequencer; control pins are registered from the current state.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_OFF;
            cnt_r   <= '0;
            pwr_r   <= 1'b0;
            bl_r    <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            pwr_r   <= (state_r != ST_OFF);
            bl_r    <= (state_r == ST_BL_UP) || (state_r == ST_RUN) || (state_r == ST_BL_DN);
            ready_r <= (state_r == ST_RUN);
            case (state_r)
                ST_OFF: begin
                    if (lcd_en) begin
                        state_r <= ST_PWR_UP;
                        cnt_r   <= PWR_LOAD;
                    end
                end
                ST_PWR_UP: begin
                    // An abort here ramps power down for the full power delay.
                    if (!lcd_en) begin
                        state_r <= ST_PWR_DN;
                        cnt_r   <= PWR_LOAD;
                    end else if (cnt_r == '0) begin
                        state_r <= ST_BL_UP;
                        cnt_r   <= BL_LOAD;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_BL_UP: begin
                    if (!lcd_en) begin
                        state_r <= ST_BL_DN;
                        cnt_r   <= BL_LOAD;
                    end else if (cnt_r == '0) begin
                        state_r <= ST_RUN;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lcd_en) begin
                        state_r <= ST_BL_DN;
                        cnt_r   <= BL_LOAD;
                    end
                end
                ST_BL_DN: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_PWR_DN;
                        cnt_r   <= PWR_LOAD;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_PWR_DN: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_OFF;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_OFF;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

`ifdef FSLCD_DITHER_EN
    logic       col_r;
    logic       line_r;
    logic       frame_r;
    logic       dx_s;
    logic [1:0] bay_s;

    function automatic logic [W-1:0] dith(input logic [W-1:0] c, input logic [1:0] bay);
        logic [W:0] off;
        logic [W:0] sum;
        off = (W+1)'(bay) << (W - WO - 2);
        sum = {1'b0, c} + off;
        return sum[W] ? {W{1'b1}} : sum[W-1:0];
    endfunction

    assign dx_s = col_r ^ frame_r;

    // 2x2 Bayer threshold for the current pixel position.
    always_comb begin
        bay_s = 2'd0;
        case ({line_r, dx_s})
            2'b00:   bay_s = 2'd0;
            2'b01:   bay_s = 2'd2;
            2'b10:   bay_s = 2'd3;
            2'b11:   bay_s = 2'd1;
            default: bay_s = 2'd0;
        endcase
    end

    // Pixel position parity; act_s1_r/vs_s1_r double as the previous-cycle inputs for edge detection.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            col_r   <= 1'b0;
            line_r  <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            col_r <= vid_active ? ~col_r : 1'b0;
            if (vsync && !vs_s1_r) begin
                line_r  <= 1'b0;
                frame_r <= ~frame_r;
            end else if (act_s1_r && !vid_active) begin
                line_r <= ~line_r;
            end
        end
    end
`endif

    // Stage 1: capture controls and (optionally dithered) pixel components.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            act_s1_r <= 1'b0;
            hs_s1_r  <= 1'b0;
            vs_s1_r  <= 1'b0;
            pix_s1_r <= '0;
        end else begin
            act_s1_r <= vid_active;
            hs_s1_r  <= hsync;
            vs_s1_r  <= vsync;
`ifdef FSLCD_DITHER_EN
            pix_s1_r <= {dith(vid_data[3*W-1 -: W], bay_s),
                         dith(vid_data[2*W-1 -: W], bay_s),
                         dith(vid_data[W-1 -: W], bay_s)};
`else
            pix_s1_r <= vid_data;
`endif
        end
    end

    // Stage 2: truncate and drive panel pins, blanked and syncs idle outside RUN.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            r         <= '0;
            g         <= '0;
            b         <= '0;
            de_r      <= 1'b0;
            hsync_out <= ~HS_ACT;
            vsync_out <= ~VS_ACT;
        end else if (state_r == ST_RUN) begin
            r         <= pix_s1_r[3*W-1 -: WO];
            g         <= pix_s1_r[2*W-1 -: WO];
            b         <= pix_s1_r[W-1 -: WO];
            de_r      <= act_s1_r;
            hsync_out <= hs_s1_r ? HS_ACT : ~HS_ACT;
            vsync_out <= vs_s1_r ? VS_ACT : ~VS_ACT;
        end else begin
            r         <= '0;
            g         <= '0;
            b         <= '0;
            de_r      <= 1'b0;
            hsync_out <= ~HS_ACT;
            vsync_out <= ~VS_ACT;
        end
    end
endmodule

// File: tb/tb_fslcd_drv.sv
// Directed bench for fslcd_drv: sequencer timing, pixel pipeline (scoreboard) and reset behaviour.
module tb_fslcd_drv;
    logic        clk = 1'b0;
    logic        resetn;
    logic        lcd_en;
    logic        vid_active;
    logic [23:0] vid_data;
    logic        hsync;
    logic        vsync;
    logic        clk_out;
    logic [5:0]  r, g, b;
    logic        hsync_out;
    logic        vsync_out;
    logic [3:0]  ctrl_out;
    logic        pwr_ready;

    typedef struct {
        int         due;
        logic       de;
        logic [17:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
`ifdef FSLCD_DITHER_EN
    logic m_col = 1'b0, m_line = 1'b0, m_frame = 1'b0, m_actp = 1'b0, m_vsp = 1'b0;
`endif

    always #5 clk = ~clk;

    fslcd_drv #(
        .C_IN_COMP_WIDTH(8), .C_OUT_COMP_WIDTH(6), .C_PWR_DLY(4), .C_BL_DLY(3),
        .C_HSYNC_POL(0), .C_VSYNC_POL(1)
    ) dut (
        .clk(clk), .resetn(resetn), .lcd_en(lcd_en), .vid_active(vid_active),
        .vid_data(vid_data), .hsync(hsync), .vsync(vsync), .clk_out(clk_out),
        .r(r), .g(g), .b(b), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .ctrl_out(ctrl_out), .pwr_ready(pwr_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [5:0] comp(input logic [7:0] c, input logic [1:0] bay);
        logic [8:0] s;
        s = {1'b0, c} + {7'd0, bay};
        if (s[8]) s = 9'h0FF;
        return s[7:2];
    endfunction

    // One clock; then compare every scoreboard entry due at this edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("pix_de", {31'd0, ctrl_out[0]}, {31'd0, e.de});
            chk("pix_rgb", {14'd0, r, g, b}, {14'd0, e.rgb});
            chk("pix_hs", {31'd0, hsync_out}, {31'd0, e.hs});
            chk("pix_vs", {31'd0, vsync_out}, {31'd0, e.vs});
        end
    endtask

    task automatic drive(input logic act, input logic [23:0] d, input logic h, input logic v, input logic want);
        exp_t e;
        logic [1:0] bay;
        bay = 2'd0;
`ifdef FSLCD_DITHER_EN
        case ({m_line, m_col ^ m_frame})
            2'b00:   bay = 2'd0;
            2'b01:   bay = 2'd2;
            2'b10:   bay = 2'd3;
            default: bay = 2'd1;
        endcase
`endif
        if (want) begin
            e.due = cyc + 2;
            e.de  = act;
            e.rgb = {comp(d[23:16], bay), comp(d[15:8], bay), comp(d[7:0], bay)};
            e.hs  = h ? 1'b0 : 1'b1;
            e.vs  = v;
            sb.push_back(e);
        end
        vid_active = act;
        vid_data   = d;
        hsync      = h;
        vsync      = v;
`ifdef FSLCD_DITHER_EN
        m_col = act ? ~m_col : 1'b0;
        if (v && !m_vsp) begin
            m_line  = 1'b0;
            m_frame = ~m_frame;
        end else if (m_actp && !act) begin
            m_line = ~m_line;
        end
        m_actp = act;
        m_vsp  = v;
`endif
        tick();
    endtask

    initial begin
        logic [3:0] ex;
        resetn = 1'b0; lcd_en = 1'b0; vid_active = 1'b0; vid_data = 24'd0; hsync = 1'b0; vsync = 1'b0;
        repeat (3) tick();
        chk("rst_ctrl", {28'd0, ctrl_out}, 32'd0);
        chk("rst_ready", {31'd0, pwr_ready}, 32'd0);
        chk("rst_rgb", {14'd0, r, g, b}, 32'd0);
        chk("rst_hs", {31'd0, hsync_out}, 32'd1);
        chk("rst_vs", {31'd0, vsync_out}, 32'd0);
        resetn = 1'b1;
        repeat (4) tick();

        // Video while OFF must stay blanked.
        repeat (3) drive(1'b1, 24'hFF8040, 1'b1, 1'b1, 1'b0);
        chk("off_ctrl", {28'd0, ctrl_out}, 32'd0);
        chk("off_rgb", {14'd0, r, g, b}, 32'd0);
        chk("off_hs", {31'd0, hsync_out}, 32'd1);
        chk("off_vs", {31'd0, vsync_out}, 32'd0);
        repeat (3) drive(1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
        chk("off_stay", {28'd0, ctrl_out}, 32'd0);

        // Power-up: lcd_en rises at T.
        lcd_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            ex = 4'b0000; ex[1] = (k >= 2); ex[2] = (k >= 6);
            chk($sformatf("up_ctrl_%0d", k), {28'd0, ctrl_out}, {28'd0, ex});
            chk($sformatf("up_ready_%0d", k), {31'd0, pwr_ready}, {31'd0, (k >= 9)});
        end

`ifdef FSLCD_DITHER_EN
        drive(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 24'h000000, 1'b0, 1'b0, 1'b1);
        for (int ln = 0; ln < 4; ln++) begin
            for (int p = 0; p < 4; p++) drive(1'b1, (ln == 1) ? 24'hFFFFFF : 24'h020202, 1'b0, 1'b0, 1'b1);
            drive(1'b0, 24'h000000, 1'b1, 1'b0, 1'b1);
            if (ln == 1) begin
                drive(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1);
                drive(1'b0, 24'h000000, 1'b0, 1'b0, 1'b1);
            end
        end
`else
        drive(1'b1, 24'hFF8040, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 24'hA5C3E7, 1'b0, 1'b0, 1'b1);
        chk("trunc_r", {26'd0, r}, 32'h3F);
        chk("trunc_g", {26'd0, g}, 32'h20);
        chk("trunc_b", {26'd0, b}, 32'h10);
        drive(1'b0, 24'h123456, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++)
            drive(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
`endif
        repeat (3) drive(1'b0, 24'h000000, 1'b0, 1'b0, 1'b0);
        chk("sb_empty", sb.size(), 32'd0);

        // Power-down from RUN: lcd_en falls at U.
        lcd_en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            ex = 4'b0000; ex[1] = (k < 9); ex[2] = (k < 5);
            chk($sformatf("dn_ctrl_%0d", k), {28'd0, ctrl_out}, {28'd0, ex});
            chk($sformatf("dn_ready_%0d", k), {31'd0, pwr_ready}, {31'd0, (k < 2)});
        end

        // Abort two cycles into PWR_UP.
        lcd_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) lcd_en = 1'b0;
            ex = 4'b0000; ex[1] = (k >= 2) && (k < 8);
            chk($sformatf("abort_ctrl_%0d", k), {28'd0, ctrl_out}, {28'd0, ex});
        end

        // Reset while running with active video.
        lcd_en = 1'b1;
        repeat (12) tick();
        chk("run_ready", {31'd0, pwr_ready}, 32'd1);
        drive(1'b1, 24'hFF8040, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 24'hFF8040, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_de", {31'd0, ctrl_out[0]}, 32'd1);
        resetn = 1'b0;
        #1;
        sb.delete();
        chk("midrst_ctrl", {28'd0, ctrl_out}, 32'd0);
        chk("midrst_rgb", {14'd0, r, g, b}, 32'd0);
        chk("midrst_ready", {31'd0, pwr_ready}, 32'd0);
        chk("midrst_hs", {31'd0, hsync_out}, 32'd1);
        tick();
        lcd_en = 1'b0; vid_active = 1'b0;
        resetn = 1'b1;
        repeat (8) tick();
        chk("post_rst_ctrl", {28'd0, ctrl_out}, 32'd0);
        chk("post_rst_ready", {31'd0, pwr_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fslcd_drv.md
Name: fslcd_drv

Overview:
- Parametrised parallel-RGB LCD driver; successor to the fixed 24-bit to 18-bit LCD adapter.
- Sits between the video timing/stream output and the panel pins.
- Registers and aligns data and syncs.
- Reduces component width with optional ordered dither.
- Runs a panel power/backlight sequencing FSM on ctrl_out.

Parameters:
- C_IN_COMP_WIDTH, 8, input bits per colour component.
- C_OUT_COMP_WIDTH, 6, output bits per component; must be <= C_IN_COMP_WIDTH.
- C_PWR_DLY, 1000000, clk cycles from panel power-on to backlight-on, and from backlight-off to power-off.
- C_BL_DLY, 1000000, clk cycles from backlight-on to RUN, and from RUN exit to backlight-off.
- C_HSYNC_POL, 1, active level of hsync_out (input hsync is active-high).
- C_VSYNC_POL, 1, active level of vsync_out (input vsync is active-high).

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- lcd_en  in  1  level request: 1 = power up panel, 0 = power down.
- vid_active  in  1  data-enable from timing generator.
- vid_data  in  3*C_IN_COMP_WIDTH  pixel data, {R,G,B} from MSB to LSB.
- hsync  in  1  horizontal sync, active-high.
- vsync  in  1  vertical sync, active-high.
- clk_out  out  1  panel clock; equals clk, not gated.
- r, g, b  out  C_OUT_COMP_WIDTH each  panel colour data.
- hsync_out  out  1  panel hsync, polarity per C_HSYNC_POL.
- vsync_out  out  1  panel vsync, polarity per C_VSYNC_POL.
- ctrl_out  out  4  bit0 = DE, bit1 = panel power, bit2 = backlight, bit3 = reserved (constant 0).
- pwr_ready  out  1  high only in RUN.

Behaviour:
- Reset:
  - Async assert on resetn low, sync release.
  - State OFF; delay counter 0; column, line and frame counters 0.
  - r, g, b = 0; ctrl_out = 4'b0000; pwr_ready = 0; syncs at inactive level.
  - Reset mid-sequence drops power and backlight immediately, with no ramp-down.
- FSM states: OFF, PWR_UP, BL_UP, RUN, BL_DN, PWR_DN. A single down-counter is loaded on each state entry.
  - OFF → PWR_UP when lcd_en = 1; ctrl[1] = 1 from PWR_UP onward.
  - PWR_UP → BL_UP after C_PWR_DLY cycles; ctrl[2] = 1 from BL_UP onward.
  - BL_UP → RUN after C_BL_DLY cycles; pwr_ready = 1.
  - RUN → BL_DN when lcd_en = 0; ctrl[2] stays 1 for C_BL_DLY cycles.
  - BL_DN → PWR_DN; ctrl[2] = 0, ctrl[1] = 1 for C_PWR_DLY cycles.
  - PWR_DN → OFF; ctrl[1] = 0.
- lcd_en dropped mid power-up:
  - In PWR_UP: go directly to PWR_DN (full C_PWR_DLY).
  - In BL_UP: go directly to BL_DN.
- lcd_en re-raised mid power-down: completes to OFF first, then restarts the up-sequence.
- ctrl_out is registered from state; it changes exactly 1 cycle after the state transition condition.
- Data path:
  - 2-cycle fixed latency. Stage 1: dither add/saturate. Stage 2: truncate and output register.
  - vid_active, hsync and vsync are delayed identically, so DE, syncs and pixels stay aligned.
  - Outside RUN: r, g, b forced to 0, ctrl[0] = 0, syncs held inactive.
  - In RUN: ctrl[0] = delayed vid_active; outputs are driven even when vid_active = 0 (blanking data passes through).
- Width rule: D = C_IN_COMP_WIDTH − C_OUT_COMP_WIDTH. Output component = upper C_OUT_COMP_WIDTH bits of the (dithered) input component. D = 0 is a straight pass.
- Counters (always running, independent of FSM):
  - col[0]: toggles on each vid_active = 1 cycle; cleared when vid_active = 0.
  - line[0]: toggles on each vid_active falling edge; cleared on vsync rising edge.
  - frame[0]: toggles on each vsync rising edge.

Optional Feature:
- Macro: FSLCD_DITHER_EN. Requires D >= 2.
- Defined:
  - Each component gets a 2x2 Bayer offset B << (D−2) added before truncation.
  - x = col[0] ^ frame[0], y = line[0].
  - B(x,y): (0,0) = 0, (1,0) = 2, (0,1) = 3, (1,1) = 1.
  - Sum saturates at all-ones; no wrap.
  - Latency unchanged at 2 cycles.
- Undefined: plain truncation. Dither counters and adders are not instantiated.

Test Plan:
- Reset: resetn = 0 in RUN with active video → next sample shows ctrl_out = 0000, r/g/b = 0, pwr_ready = 0. Release, lcd_en = 0 → stays OFF.
- Power sequence (C_PWR_DLY = 4, C_BL_DLY = 3): lcd_en rises at cycle T →
  - ctrl[1] = 1 at T+2.
  - ctrl[2] = 1 at T+6.
  - pwr_ready = 1 at T+9.
  - lcd_en = 0 → ctrl[2] falls 3 cycles later, then ctrl[1] falls 4 cycles after that.
- Abort: lcd_en drops 2 cycles into PWR_UP → ctrl[2] never rises; ctrl[1] falls after 4 PWR_DN cycles; FSM in OFF.
- Truncation, no macro, in RUN: vid_active = 1, vid_data = 24'hFF8040 → 2 cycles later r = 6'h3F, g = 6'h20, b = 6'h10, ctrl[0] = 1. Syncs delayed by 2; C_HSYNC_POL = 0 gives inverted hsync_out.
- Dither, macro defined, flat 24'h020202, frame 0:
  - Line 0: pixels alternate 0, 1.
  - Line 1: pixels alternate 1, 0.
  - Next frame: pattern swapped horizontally.
- Saturation, macro defined: 24'hFFFFFF at B = 3 → r = g = b = 6'h3F, with no wrap to 0.
